// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the autobaud UART receiver:
//   state_t   - receiver FSM states (PARITY exists only with UART_RX_PARITY_EN)
//   SYNC_CHAR - character the far end sends to let the receiver measure baud
//   majority  - bit decision from the count of ones among the oversamples
// Optional feature macro: UART_RX_PARITY_EN
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_AUTOBAUD = 3'd0,
    ST_IDLE     = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
`ifdef UART_RX_PARITY_EN
    ST_PARITY   = 3'd4,
`endif
    ST_STOP     = 3'd5,
    ST_BREAK    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_CHAR = 8'h55;

  // A tie between ones and zeros resolves to 1 (idle level), so a short
  // low glitch on an idle line is rejected rather than taken as a start bit.
  function automatic logic majority(input int ones, input int width);
    return (ones >= (width / 2));
  endfunction

endpackage

// File: rtl/uart_rx_autobaud.sv
// uart_rx_autobaud
// Measures the edge-to-edge interval of the sync character and averages it
// into a clocks-per-bit estimate.
// Ports:
//   CLK, RESETn   clock, asynchronous active-low reset
//   en            measurement active (receiver in AUTOBAUD)
//   restart       discard everything measured so far, CPB back to 0
//   rx_edge       synchronised line changed level this cycle
//   cpb           running clocks-per-bit estimate
//   done          one-cycle pulse on the final sync edge
module uart_rx_autobaud
  import uart_rx_pkg::*;
#(
  parameter int CPB_WIDTH  = 12,
  parameter int SYNC_EDGES = 10
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 en,
  input  logic                 restart,
  input  logic                 rx_edge,
  output logic [CPB_WIDTH-1:0] cpb,
  output logic                 done
);

  localparam int EW = $clog2(SYNC_EDGES + 1);

  logic [CPB_WIDTH-1:0] acc_reg, acc_next;
  logic [CPB_WIDTH-1:0] cpb_reg, cpb_next;
  logic [EW-1:0]        edge_cnt_reg, edge_cnt_next;
  logic [CPB_WIDTH:0]   avg_sum;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc_reg      <= '0;
      cpb_reg      <= '0;
      edge_cnt_reg <= '0;
    end else begin
      acc_reg      <= acc_next;
      cpb_reg      <= cpb_next;
      edge_cnt_reg <= edge_cnt_next;
    end
  end

  always_comb begin
    acc_next      = acc_reg;
    cpb_next      = cpb_reg;
    edge_cnt_next = edge_cnt_reg;
    done          = 1'b0;
    // One extra bit so the average of two near-full values cannot wrap.
    avg_sum = {1'b0, cpb_reg} + {1'b0, acc_reg} + (CPB_WIDTH + 1)'(1);

    if (restart) begin
      acc_next      = '0;
      cpb_next      = '0;
      edge_cnt_next = '0;
    end else if (en) begin
      if (rx_edge) begin
        acc_next = '0;
        if (edge_cnt_reg == '0) begin
          edge_cnt_next = EW'(1);
        end else begin
          // acc holds interval-1 at the closing edge.
          if (edge_cnt_reg == EW'(1)) cpb_next = acc_reg + CPB_WIDTH'(1);
          else                        cpb_next = avg_sum[CPB_WIDTH:1];
          if (edge_cnt_reg == EW'(SYNC_EDGES - 1)) begin
            done          = 1'b1;
            edge_cnt_next = '0;
          end else begin
            edge_cnt_next = edge_cnt_reg + EW'(1);
          end
        end
      end else if (edge_cnt_reg != '0) begin
        // Interval too long to be the sync character: start over.
        if (acc_reg == '1) begin
          acc_next      = '0;
          edge_cnt_next = '0;
          cpb_next      = '0;
        end else begin
          acc_next = acc_reg + CPB_WIDTH'(1);
        end
      end
    end
  end

  assign cpb = cpb_reg;

endmodule

// File: rtl/uart_rx_auto.sv
// uart_rx_auto
// UART receiver with autobaud lock, oversampled majority voting, break
// detection and saturating error counters.
// Optional feature macro: UART_RX_PARITY_EN (adds PAR_EN, PAR_ODD, PAR_ERR
// and a parity bit between data and stop).
// Ports:
//   CLK, RESETn   clock, asynchronous active-low reset
//   RX_PIN        raw serial input (asynchronous)
//   REBAUD        pulse: abort and re-measure the baud rate
//   CPB, LOCKED   measured clocks per bit (0 until locked), lock flag
//   WRDATA, WREN  received character and one-cycle write strobe
//   WRFULL        downstream FIFO full; frame is dropped and counted
//   FRM_ERR       framing error count, OVF_ERR dropped-frame count
//   PAR_ERR       parity error count (parity build only)
//   BREAK         line held in break
module uart_rx_auto
  import uart_rx_pkg::*;
#(
  parameter int CPB_WIDTH  = 12,
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int SYNC_EDGES = 10,
  parameter int ERR_WIDTH  = 10
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 RX_PIN,
  input  logic                 REBAUD,
  output logic [CPB_WIDTH-1:0] CPB,
  output logic                 LOCKED,
  output logic [DATA_BITS-1:0] WRDATA,
  output logic                 WREN,
  input  logic                 WRFULL,
  output logic [ERR_WIDTH-1:0] FRM_ERR,
  output logic [ERR_WIDTH-1:0] OVF_ERR,
`ifdef UART_RX_PARITY_EN
  input  logic                 PAR_EN,
  input  logic                 PAR_ODD,
  output logic [ERR_WIDTH-1:0] PAR_ERR,
`endif
  output logic                 BREAK
);

  localparam int OS_LOG2 = $clog2(OVERSAMPLE);
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int OW      = $clog2(OVERSAMPLE + 1);
  localparam int BC_W    = $clog2(DATA_BITS);
  localparam logic [DATA_BITS-1:0] SYNC_DATA = DATA_BITS'(SYNC_CHAR);

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (v == '1) ? v : v + ERR_WIDTH'(1);
  endfunction

  // Synchroniser and edge detect; flops reset to the idle (high) level.
  logic sync1_reg, rx, rx_prev_reg, rx_edge;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_reg   <= 1'b1;
      rx          <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= RX_PIN;
      rx          <= sync1_reg;
      rx_prev_reg <= rx;
    end
  end

  assign rx_edge = rx ^ rx_prev_reg;

  state_t state_reg, state_next;
  logic [CPB_WIDTH-1:0] cpb_raw, tick_period, cpb_shift;
  logic                 ab_done;

  uart_rx_autobaud #(
    .CPB_WIDTH  (CPB_WIDTH),
    .SYNC_EDGES (SYNC_EDGES)
  ) u_autobaud (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .en      (state_reg == ST_AUTOBAUD),
    .restart (REBAUD),
    .rx_edge (rx_edge),
    .cpb     (cpb_raw),
    .done    (ab_done)
  );

  assign cpb_shift   = cpb_raw >> OS_LOG2;
  assign tick_period = (cpb_shift == '0) ? CPB_WIDTH'(1) : cpb_shift;

  logic [CPB_WIDTH-1:0] tick_cnt_reg, tick_cnt_next;
  logic [SC_W-1:0]      samp_cnt_reg, samp_cnt_next;
  logic [OW-1:0]        ones_reg, ones_next;
  logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] wrdata_reg, wrdata_next;
  logic                 wren_reg, wren_next;
  logic                 locked_reg, locked_next;
  logic                 brk_reg, brk_next;
  logic [ERR_WIDTH-1:0] frm_reg, frm_next;
  logic [ERR_WIDTH-1:0] ovf_reg, ovf_next;
`ifdef UART_RX_PARITY_EN
  logic [ERR_WIDTH-1:0] par_err_reg, par_err_next;
  logic                 par_bad_reg, par_bad_next;
`endif
  logic sampling, tick, bit_done, bit_val;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg    <= ST_AUTOBAUD;
      tick_cnt_reg <= '0;
      samp_cnt_reg <= '0;
      ones_reg     <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      wrdata_reg   <= '0;
      wren_reg     <= 1'b0;
      locked_reg   <= 1'b0;
      brk_reg      <= 1'b0;
      frm_reg      <= '0;
      ovf_reg      <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_reg  <= '0;
      par_bad_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      samp_cnt_reg <= samp_cnt_next;
      ones_reg     <= ones_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      wrdata_reg   <= wrdata_next;
      wren_reg     <= wren_next;
      locked_reg   <= locked_next;
      brk_reg      <= brk_next;
      frm_reg      <= frm_next;
      ovf_reg      <= ovf_next;
`ifdef UART_RX_PARITY_EN
      par_err_reg  <= par_err_next;
      par_bad_reg  <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    samp_cnt_next = samp_cnt_reg;
    ones_next     = ones_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    wrdata_next   = wrdata_reg;
    wren_next     = 1'b0;
    locked_next   = locked_reg;
    brk_next      = brk_reg;
    frm_next      = frm_reg;
    ovf_next      = ovf_reg;
`ifdef UART_RX_PARITY_EN
    par_err_next  = par_err_reg;
    par_bad_next  = par_bad_reg;
`endif
    bit_done = 1'b0;
    bit_val  = majority(int'(ones_reg) + int'(rx), OVERSAMPLE);
    tick     = (tick_cnt_reg == tick_period - CPB_WIDTH'(1));

    sampling = (state_reg == ST_START) || (state_reg == ST_DATA) ||
               (state_reg == ST_STOP);
`ifdef UART_RX_PARITY_EN
    if (state_reg == ST_PARITY) sampling = 1'b1;
`endif

    // Oversampling engine shared by every bit-receiving state; bit_done
    // marks the cycle holding the last sample of a bit.
    if (sampling) begin
      if (tick) begin
        tick_cnt_next = '0;
        if (samp_cnt_reg == SC_W'(OVERSAMPLE - 1)) begin
          samp_cnt_next = '0;
          ones_next     = '0;
          bit_done      = 1'b1;
        end else begin
          samp_cnt_next = samp_cnt_reg + SC_W'(1);
          ones_next     = ones_reg + OW'(rx);
        end
      end else begin
        tick_cnt_next = tick_cnt_reg + CPB_WIDTH'(1);
      end
    end

    case (state_reg)
      ST_AUTOBAUD: begin
        if (ab_done) begin
          locked_next = 1'b1;
          wrdata_next = SYNC_DATA;
          if (!WRFULL) wren_next = 1'b1;
          else         ovf_next  = sat_inc(ovf_reg);
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!rx) begin
          state_next    = ST_START;
          // Start half a tick in so samples sit away from the bit edges.
          tick_cnt_next = tick_period >> 1;
          samp_cnt_next = '0;
          ones_next     = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_next  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          if (bit_val) begin
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_next = {bit_val, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt_reg == BC_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PAR_EN ? ST_PARITY : ST_STOP;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BC_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          par_bad_next = (^shift_reg) ^ bit_val ^ PAR_ODD;
          state_next   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          state_next = ST_IDLE;
          if (bit_val) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_reg) begin
              par_err_next = sat_inc(par_err_reg);
            end else
`endif
            if (!WRFULL) begin
              wren_next   = 1'b1;
              wrdata_next = shift_reg;
            end else begin
              ovf_next = sat_inc(ovf_reg);
            end
          end else if (shift_reg == '0) begin
            state_next = ST_BREAK;
            brk_next   = 1'b1;
          end else begin
            frm_next = sat_inc(frm_reg);
          end
        end
      end
      ST_BREAK: begin
        if (rx) begin
          brk_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_AUTOBAUD;
    endcase

    if (REBAUD) begin
      state_next  = ST_AUTOBAUD;
      wren_next   = 1'b0;
      locked_next = 1'b0;
      brk_next    = 1'b0;
    end
  end

  assign CPB     = locked_reg ? cpb_raw : '0;
  assign LOCKED  = locked_reg;
  assign WRDATA  = wrdata_reg;
  assign WREN    = wren_reg;
  assign FRM_ERR = frm_reg;
  assign OVF_ERR = ovf_reg;
  assign BREAK   = brk_reg;
`ifdef UART_RX_PARITY_EN
  assign PAR_ERR = par_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_auto.sv
module tb_uart_rx_auto;

  localparam int EW = 5;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          RX_PIN = 1'b1;
  logic          REBAUD = 1'b0;
  logic [11:0]   CPB;
  logic          LOCKED;
  logic [7:0]    WRDATA;
  logic          WREN;
  logic          WRFULL = 1'b0;
  logic [EW-1:0] FRM_ERR;
  logic [EW-1:0] OVF_ERR;
  logic          BREAK;
`ifdef UART_RX_PARITY_EN
  logic          PAR_EN = 1'b0;
  logic          PAR_ODD = 1'b0;
  logic [EW-1:0] PAR_ERR;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_rx_auto #(.ERR_WIDTH(EW)) dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .RX_PIN  (RX_PIN),
    .REBAUD  (REBAUD),
    .CPB     (CPB),
    .LOCKED  (LOCKED),
    .WRDATA  (WRDATA),
    .WREN    (WREN),
    .WRFULL  (WRFULL),
    .FRM_ERR (FRM_ERR),
    .OVF_ERR (OVF_ERR),
`ifdef UART_RX_PARITY_EN
    .PAR_EN  (PAR_EN),
    .PAR_ODD (PAR_ODD),
    .PAR_ERR (PAR_ERR),
`endif
    .BREAK   (BREAK)
  );

  // Scoreboard monitor: every write strobe must match the oldest expected byte.
  always @(negedge CLK) begin
    if (RESETn && WREN) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got WREN with data %h, expected no write", WRDATA);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        if (WRDATA !== exp_b) begin
          errors++;
          $display("FAIL write_data: got %h, expected %h", WRDATA, exp_b);
        end else begin
          $display("write data=%h ok", WRDATA);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives start, 8 data bits LSB first, optional parity, stop, one idle bit.
  task automatic send_frame(input logic [7:0] data, input int cpb, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    RX_PIN = 1'b0;
    wait_cyc(cpb);
    for (int i = 0; i < 8; i++) begin
      RX_PIN = data[i];
      wait_cyc(cpb);
    end
    if (use_par) begin
      RX_PIN = par_bit;
      wait_cyc(cpb);
    end
    RX_PIN = stop_bit;
    wait_cyc(cpb);
    RX_PIN = 1'b1;
    wait_cyc(cpb);
    $display("sent frame %h cpb=%0d stop=%0b", data, cpb, stop_bit);
  endtask

  initial begin
    // Reset state
    wait_cyc(4);
    chk("rst_cpb", int'(CPB), 0);
    chk("rst_locked", int'(LOCKED), 0);
    chk("rst_wren", int'(WREN), 0);
    chk("rst_wrdata", int'(WRDATA), 0);
    chk("rst_frm", int'(FRM_ERR), 0);
    chk("rst_ovf", int'(OVF_ERR), 0);
    chk("rst_break", int'(BREAK), 0);
    RESETn = 1'b1;
    wait_cyc(20);

    // Autobaud at 104 then a data byte
    exp_q.push_back(8'h55);
    send_frame(8'h55, 104, 1'b1, 1'b0, 1'b0);
    chk("lock_locked", int'(LOCKED), 1);
    chk_range("lock_cpb", int'(CPB), 103, 105);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 104, 1'b1, 1'b0, 1'b0);

    // Stop bit forced low
    send_frame(8'h3C, 104, 1'b0, 1'b0, 1'b0);
    wait_cyc(104);
    chk("frm_err_one", int'(FRM_ERR), 1);

    // Break: line low two frame times
    RX_PIN = 1'b0;
    wait_cyc(104 * 19);
    chk("break_high", int'(BREAK), 1);
    wait_cyc(104);
    RX_PIN = 1'b1;
    wait_cyc(20);
    chk("break_cleared", int'(BREAK), 0);
    chk("break_no_frm", int'(FRM_ERR), 1);
    wait_cyc(104);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 104, 1'b1, 1'b0, 1'b0);

    // REBAUD in the middle of the data bits of 0x77 (line high at the time)
    RX_PIN = 1'b0;
    wait_cyc(104);
    RX_PIN = 1'b1;
    wait_cyc(104 + 52);
    REBAUD = 1'b1;
    wait_cyc(1);
    REBAUD = 1'b0;
    wait_cyc(1);
    chk("rebaud_locked", int'(LOCKED), 0);
    chk("rebaud_cpb", int'(CPB), 0);
    wait_cyc(104 * 10);

    // Relock at 52
    exp_q.push_back(8'h55);
    send_frame(8'h55, 52, 1'b1, 1'b0, 1'b0);
    chk("relock_locked", int'(LOCKED), 1);
    chk_range("relock_cpb", int'(CPB), 51, 53);

    // Overflow accounting and saturation
    WRFULL = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(8'(8'h40 + i), 52, 1'b1, 1'b0, 1'b0);
    chk("ovf_twenty", int'(OVF_ERR), 20);
    for (int i = 0; i < 15; i++) send_frame(8'h9E, 52, 1'b1, 1'b0, 1'b0);
    chk("ovf_saturated", int'(OVF_ERR), (1 << EW) - 1);
    WRFULL = 1'b0;
    exp_q.push_back(8'hC5);
    send_frame(8'hC5, 52, 1'b1, 1'b0, 1'b0);
    chk("frm_after_ovf", int'(FRM_ERR), 1);

`ifdef UART_RX_PARITY_EN
    PAR_EN  = 1'b1;
    PAR_ODD = 1'b0;
    send_frame(8'h07, 52, 1'b1, 1'b1, 1'b0);
    chk("par_err_one", int'(PAR_ERR), 1);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 52, 1'b1, 1'b1, 1'b1);
    chk("par_err_hold", int'(PAR_ERR), 1);
    PAR_EN = 1'b0;
`endif

    wait_cyc(200);
    chk("writes_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
